// File: rtl/sd_image_server.sv
// sd_image_server: responder for the u765 sector-buffer interface.
// Serves 512-byte sector reads/writes from disk images held in a
// byte-wide SDRAM port. One byte moves per memory handshake; sectors
// beyond the image size read as 8'hFF and discard writes.
module sd_image_server #(
    parameter int                MEM_AW = 23,
    parameter logic [MEM_AW-1:0] BASE0  = 23'h400000,
    parameter logic [MEM_AW-1:0] BASE1  = 23'h600000
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic [31:0]       img_size0,
    input  logic [31:0]       img_size1,
    input  logic [31:0]       sd_lba,
    input  logic [1:0]        sd_rd,
    input  logic [1:0]        sd_wr,
    output logic              sd_ack,
    output logic [8:0]        sd_buff_addr,
    output logic [7:0]        sd_buff_dout,
    input  logic [7:0]        sd_buff_din,
    output logic              sd_buff_wr,
    output logic [MEM_AW-1:0] mem_addr,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [7:0]        mem_dout,
    input  logic [7:0]        mem_din,
    input  logic              mem_ready
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_ACK       = 3'd1;
    localparam logic [2:0] S_RD_REQ    = 3'd2;
    localparam logic [2:0] S_RD_PUT    = 3'd3;
    localparam logic [2:0] S_WR_ADDR   = 3'd4;
    localparam logic [2:0] S_WR_SETTLE = 3'd5;
    localparam logic [2:0] S_WR_REQ    = 3'd6;
    localparam logic [2:0] S_DONE      = 3'd7;

    logic [2:0]        state;
    logic              is_wr;
    logic              oob;
    logic [MEM_AW-1:0] start;
    logic [8:0]        idx;

    logic              req_any;
    logic              pick1;
    logic              pick_wr;
    logic [31:0]       pick_size;
    logic [MEM_AW-1:0] pick_base;
    logic [40:0]       lba_bytes;
    logic [MEM_AW-1:0] start_nxt;

    // Request arbitration: drive 0 beats drive 1, read beats write.
    always_comb begin
        pick1     = !(sd_rd[0] | sd_wr[0]);
        pick_wr   = pick1 ? !sd_rd[1] : !sd_rd[0];
        pick_size = pick1 ? img_size1 : img_size0;
        pick_base = pick1 ? BASE1 : BASE0;
    end

    assign req_any   = |(sd_rd | sd_wr);
    // 41-bit byte offset so a large lba can never wrap below the image size.
    assign lba_bytes = {sd_lba, 9'b0};
    // Only lba[13:0] forms the address; the sum wraps inside the memory space.
    assign start_nxt = pick_base + MEM_AW'({sd_lba[13:0], 9'b0});

    // idx wraps 511 -> 0 on the final byte, so the buffer address reads 0
    // again in DONE and IDLE without extra logic.
    assign sd_buff_addr = idx;
    assign mem_addr     = start + MEM_AW'(idx);
    assign sd_ack       = (state != S_IDLE) && (state != S_DONE);
    assign mem_rd       = (state == S_RD_REQ) && !oob;
    assign mem_wr       = (state == S_WR_REQ) && !oob;
    assign sd_buff_wr   = (state == S_RD_PUT);

    // Transfer sequencer: accept, then shuttle one byte per loop until 512 done.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            is_wr        <= 1'b0;
            oob          <= 1'b0;
            start        <= '0;
            idx          <= '0;
            sd_buff_dout <= '0;
            mem_dout     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_any) begin
                        is_wr <= pick_wr;
                        oob   <= (lba_bytes >= {9'b0, pick_size});
                        start <= start_nxt;
                        idx   <= '0;
                        state <= S_ACK;
                    end
                end
                S_ACK: state <= is_wr ? S_WR_ADDR : S_RD_REQ;
                S_RD_REQ: begin
                    if (oob) begin
                        sd_buff_dout <= 8'hFF;
                        state        <= S_RD_PUT;
                    end else if (mem_ready) begin
                        sd_buff_dout <= mem_din;
                        state        <= S_RD_PUT;
                    end
                end
                S_RD_PUT: begin
                    idx   <= idx + 9'd1;
                    state <= (idx == 9'd511) ? S_DONE : S_RD_REQ;
                end
                S_WR_ADDR: state <= S_WR_SETTLE;
                S_WR_SETTLE: begin
                    // Buffer data lags the address by one cycle.
                    mem_dout <= sd_buff_din;
                    state    <= S_WR_REQ;
                end
                S_WR_REQ: begin
                    if (oob || mem_ready) begin
                        idx   <= idx + 9'd1;
                        state <= (idx == 9'd511) ? S_DONE : S_WR_ADDR;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_image_server.sv
// Directed bench for sd_image_server: table of sector transfers plus
// hand-written sequences for arbitration and mid-transfer reset.
module tb_sd_image_server;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] img_size0 = '0, img_size1 = '0, sd_lba = '0;
    logic [1:0]  sd_rd = '0, sd_wr = '0;
    logic        sd_ack, sd_buff_wr, mem_rd, mem_wr;
    logic [8:0]  sd_buff_addr;
    logic [7:0]  sd_buff_dout, mem_dout;
    logic [7:0]  sd_buff_din = '0, mem_din = '0;
    logic [22:0] mem_addr;
    logic        mem_ready = 1'b0;

    sd_image_server dut (
        .clk_sys(clk_sys), .reset_n(reset_n),
        .img_size0(img_size0), .img_size1(img_size1),
        .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
        .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout),
        .sd_buff_din(sd_buff_din), .sd_buff_wr(sd_buff_wr),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_dout(mem_dout), .mem_din(mem_din), .mem_ready(mem_ready)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        string       name;
        logic        drv;
        logic        wr;
        logic [31:0] lba;
        logic [31:0] size;
        int          lat;   // 0 = random 1..20
        logic [22:0] base;
        logic        oob;
    } vec_t;

    int errors = 0, checks = 0;
    int lat_cfg = 1;
    logic        exp_wr = 1'b0, exp_oob = 1'b0;
    logic [22:0] exp_base = '0;
    int n_rd, n_wr, n_stb, bad_rd, bad_wr, bad_stb, bad_proto;
    logic [7:0] ibuf [512];

    function automatic logic [7:0] pat(input logic [22:0] a);
        return a[7:0] ^ a[15:8] ^ {1'b0, a[22:16]} ^ 8'h5A;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic clr_tally();
        n_rd = 0; n_wr = 0; n_stb = 0;
        bad_rd = 0; bad_wr = 0; bad_stb = 0; bad_proto = 0;
    endtask

    task automatic wait_ack(input logic val, input string nm);
        int n = 0;
        while (sd_ack !== val && n < 40000) begin
            @(negedge clk_sys);
            n++;
        end
        chk({nm, " ack wait"}, sd_ack, val);
    endtask

    // SDRAM responder, initiator buffer and strobe monitor, all on negedge.
    initial begin
        logic        active;
        int          elapsed, target;
        logic [22:0] held;
        logic [8:0]  last_addr;
        logic        prev_stb;
        active = 1'b0; elapsed = 0; target = 1; held = '0;
        last_addr = '0; prev_stb = 1'b0;
        clr_tally();
        forever begin
            @(negedge clk_sys);
            mem_ready   = 1'b0;
            sd_buff_din = ibuf[last_addr];
            last_addr   = sd_buff_addr;
            if (mem_rd && mem_wr) bad_proto++;
            if (sd_buff_wr) begin
                if (!sd_ack || exp_wr || prev_stb) bad_proto++;
                if (sd_buff_addr != n_stb[8:0] ||
                    sd_buff_dout != (exp_oob ? 8'hFF : pat(exp_base + 23'(n_stb))))
                    bad_stb++;
                n_stb++;
            end
            prev_stb = sd_buff_wr;
            if (reset_n && (mem_rd || mem_wr)) begin
                if (!active) begin
                    active  = 1'b1;
                    elapsed = 0;
                    held    = mem_addr;
                    target  = (lat_cfg == 0) ? int'($urandom_range(20, 1)) : lat_cfg;
                end else if (mem_addr != held) bad_proto++;
                elapsed++;
                if (elapsed >= target) begin
                    mem_ready = 1'b1;
                    active    = 1'b0;
                    if (mem_rd) begin
                        mem_din = pat(mem_addr);
                        if (mem_addr != exp_base + 23'(n_rd) || exp_wr) bad_rd++;
                        n_rd++;
                    end else begin
                        if (mem_addr != exp_base + 23'(n_wr) || mem_dout != ibuf[n_wr[8:0]] || !exp_wr)
                            bad_wr++;
                        n_wr++;
                    end
                end
            end else begin
                active = 1'b0;
            end
        end
    end

    task automatic post_checks(input string nm, input logic wr, input logic oob);
        chk({nm, " strobes"}, n_stb, wr ? 0 : 512);
        chk({nm, " mem_rd cnt"}, n_rd, (!wr && !oob) ? 512 : 0);
        chk({nm, " mem_wr cnt"}, n_wr, (wr && !oob) ? 512 : 0);
        chk({nm, " strobe data"}, bad_stb, 0);
        chk({nm, " rd addr"}, bad_rd, 0);
        chk({nm, " wr addr/data"}, bad_wr, 0);
        chk({nm, " protocol"}, bad_proto, 0);
        chk({nm, " buff_addr idle"}, sd_buff_addr, 0);
    endtask

    task automatic run_xfer(input vec_t v);
        @(negedge clk_sys);
        if (v.drv) img_size1 = v.size; else img_size0 = v.size;
        sd_lba = v.lba; lat_cfg = v.lat;
        exp_wr = v.wr; exp_oob = v.oob; exp_base = v.base;
        clr_tally();
        if (v.wr) sd_wr[v.drv] = 1'b1; else sd_rd[v.drv] = 1'b1;
        @(negedge clk_sys);
        chk({v.name, " ack rise"}, sd_ack, 1);
        // Request, lba and size are all ignored after acceptance.
        sd_rd = '0; sd_wr = '0;
        sd_lba = 32'hDEAD_BEEF; img_size0 = '0; img_size1 = '0;
        wait_ack(1'b0, v.name);
        @(negedge clk_sys);
        post_checks(v.name, v.wr, v.oob);
    endtask

    vec_t vecs [11];

    initial begin
        vecs[0]  = '{"rd0_lba3",  1'b0, 1'b0, 32'd3,        32'd194816,    1, 23'h400600, 1'b0};
        vecs[1]  = '{"wr1_lba0",  1'b1, 1'b1, 32'd0,        32'd194816,    1, 23'h600000, 1'b0};
        vecs[2]  = '{"rd0_oob",   1'b0, 1'b0, 32'd2,        32'd1024,      1, 23'h400400, 1'b1};
        vecs[3]  = '{"wr0_oob",   1'b0, 1'b1, 32'd2,        32'd1024,      1, 23'h400400, 1'b1};
        vecs[4]  = '{"rd0_rand",  1'b0, 1'b0, 32'd5,        32'd194816,    0, 23'h400A00, 1'b0};
        vecs[5]  = '{"rd1_hibit", 1'b1, 1'b0, 32'h4001,     32'h01000000,  2, 23'h600200, 1'b0};
        vecs[6]  = '{"rd0_last",  1'b0, 1'b0, 32'd380,      32'd194816,    1, 23'h42F800, 1'b0};
        vecs[7]  = '{"rd0_past",  1'b0, 1'b0, 32'd381,      32'd194816,    1, 23'h42FA00, 1'b1};
        vecs[8]  = '{"rd1_nosz",  1'b1, 1'b0, 32'd0,        32'd0,         1, 23'h600000, 1'b1};
        vecs[9]  = '{"wr1_wrap",  1'b1, 1'b1, 32'h3FFF,     32'hFFFFFFFF,  3, 23'h5FFE00, 1'b0};
        vecs[10] = '{"rd0_wide",  1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF,  1, 23'h3FFE00, 1'b1};
        for (int k = 0; k < 512; k++) ibuf[k] = 8'(k * 7 + 3) ^ 8'hA5;

        // Reset state
        repeat (3) @(negedge clk_sys);
        chk("reset outs", {sd_ack, sd_buff_addr, sd_buff_dout, sd_buff_wr,
                           mem_addr, mem_rd, mem_wr, mem_dout}, 0);
        reset_n = 1'b1;
        @(negedge clk_sys);
        chk("idle ack", sd_ack, 0);

        for (int k = 0; k < 11; k++) run_xfer(vecs[k]);

        // Simultaneous drive-1 read and drive-0 write: drive 0 goes first.
        @(negedge clk_sys);
        img_size0 = 32'd194816; img_size1 = 32'd194816; sd_lba = 32'd1;
        lat_cfg = 1; exp_wr = 1'b1; exp_oob = 1'b0; exp_base = 23'h400200;
        clr_tally();
        sd_rd = 2'b10; sd_wr = 2'b01;
        @(negedge clk_sys);
        chk("arb ack rise", sd_ack, 1);
        sd_wr = 2'b00; sd_lba = 32'd7;
        wait_ack(1'b0, "arb wr0");
        chk("arb wr0 mem_wr cnt", n_wr, 512);
        chk("arb wr0 strobes", n_stb, 0);
        chk("arb wr0 data", bad_wr, 0);
        exp_wr = 1'b0; exp_base = 23'h600E00;
        clr_tally();
        @(negedge clk_sys);
        chk("arb ack gap", sd_ack, 0);
        @(negedge clk_sys);
        chk("arb rd1 accept", sd_ack, 1);
        sd_rd = 2'b00;
        wait_ack(1'b0, "arb rd1");
        @(negedge clk_sys);
        post_checks("arb rd1", 1'b0, 1'b0);

        // Reset during byte 100 of a read with mem_rd pending.
        @(negedge clk_sys);
        img_size0 = 32'd194816; sd_lba = 32'd3; lat_cfg = 5;
        exp_wr = 1'b0; exp_oob = 1'b0; exp_base = 23'h400600;
        clr_tally();
        sd_rd = 2'b01;
        @(negedge clk_sys);
        sd_rd = 2'b00;
        begin
            int n = 0;
            do begin
                @(negedge clk_sys); #1;
                n++;
            end while (!(n_stb == 100 && mem_rd) && n < 20000);
            chk("rst reach byte100", n_stb, 100);
        end
        reset_n = 1'b0;
        #1;
        chk("rst ack", sd_ack, 0);
        chk("rst mem_rd", mem_rd, 0);
        chk("rst buff_wr", sd_buff_wr, 0);
        chk("rst buff_addr", sd_buff_addr, 0);
        @(negedge clk_sys);
        reset_n = 1'b1;
        run_xfer('{"rst_restart", 1'b0, 1'b0, 32'd3, 32'd194816, 2, 23'h400600, 1'b0});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sd_image_server.md
Name: sd_image_server

Overview:
- Responder end of the sector-buffer interface that `u765` drives as initiator (`sd_lba`/`sd_rd`/`sd_wr`/`sd_ack`/`sd_buff_*`).
- Serves 512-byte sector reads and writes from a disk image held in SDRAM, as a RAM-disk alternative to SD-card-backed `mist_io` sector transfer.
- Sits between `u765` and a byte-wide SDRAM port arbitrated alongside the CPU/ioctl paths.

Parameters:
- `MEM_AW`, 23, width of the byte address into SDRAM.
- `BASE0`, 23'h400000, SDRAM byte address of the drive 0 image.
- `BASE1`, 23'h600000, SDRAM byte address of the drive 1 image.

Ports:
- `clk_sys`  in  1  system clock.
- `reset_n`  in  1  asynchronous active-low reset.
- `img_size0`  in  32  drive 0 image bytes; 0 means no image.
- `img_size1`  in  32  drive 1 image bytes; 0 means no image.
- `sd_lba`  in  32  sector number; sampled at request acceptance.
- `sd_rd`  in  2  per-drive read request (level).
- `sd_wr`  in  2  per-drive write request (level).
- `sd_ack`  out  1  transfer in progress.
- `sd_buff_addr`  out  9  byte index within the sector.
- `sd_buff_dout`  out  8  read data to the initiator.
- `sd_buff_din`  in  8  write data from the initiator; valid 1 cycle after `sd_buff_addr` changes.
- `sd_buff_wr`  out  1  1-cycle strobe; `sd_buff_dout` valid.
- `mem_addr`  out  `MEM_AW`  SDRAM byte address.
- `mem_rd`  out  1  read request; held until `mem_ready`.
- `mem_wr`  out  1  write request; held until `mem_ready`.
- `mem_dout`  out  8  write data to SDRAM.
- `mem_din`  in  8  read data; valid in the `mem_ready` cycle.
- `mem_ready`  in  1  1-cycle completion pulse.

Behaviour:
- Reset: all outputs 0, FSM in IDLE. Asynchronous reset mid-transfer aborts at once; any outstanding `mem_rd`/`mem_wr` is dropped without waiting for `mem_ready`.
- States: IDLE, ACK, RD_REQ, RD_PUT, WR_ADDR, WR_SETTLE, WR_REQ, DONE.
- IDLE accepts when any bit of `sd_rd | sd_wr` is high.
  - Drive 0 wins over drive 1; read wins over write on the same drive.
  - Latches drive, op and `sd_lba`.
  - Computes `start = BASEn + {sd_lba[13:0], 9'b0}` truncated to `MEM_AW`.
  - Sets `oob = (sd_lba*512 >= img_sizen)`, computed at 41-bit width so there is no wrap.
  - Sets byte index i = 0.
  - Next state is ACK.
- ACK:
  - `sd_ack` goes 1 and stays 1 until DONE.
  - The initiator drops its request on seeing ack; the request level is ignored after acceptance.
  - Next state: RD_REQ if the op is read, WR_ADDR if write.
- Read path:
  - RD_REQ drives `mem_addr = start + i` and `mem_rd = 1`.
  - On `mem_ready`: `mem_rd` drops, `sd_buff_dout` takes `mem_din`, go to RD_PUT.
  - If `oob`, skip memory entirely: `sd_buff_dout = 8'hFF`, go to RD_PUT the cycle after entry.
  - RD_PUT holds `sd_buff_addr = i`, pulses `sd_buff_wr` for exactly 1 cycle, then i+1 and back to RD_REQ. After i = 511 go to DONE.
  - A non-oob byte costs at least 2 cycles plus memory latency.
- Write path:
  - WR_ADDR drives `sd_buff_addr = i`.
  - WR_SETTLE waits 1 cycle, then captures `sd_buff_din` into `mem_dout`.
  - WR_REQ asserts `mem_wr` at `start + i` until `mem_ready`, then i+1 and back to WR_ADDR. After i = 511 go to DONE.
  - If `oob`, no `mem_wr` is issued; data is read from the buffer and discarded, same sequencing otherwise.
- DONE:
  - `sd_ack` = 0 and `sd_buff_addr` = 0.
  - Return to IDLE next cycle; the earliest new acceptance is 2 cycles after ack falls.
- Never assert `mem_rd` and `mem_wr` together. Never assert `sd_buff_wr` outside ack or during a write op.
- `mem_ready` outside RD_REQ/WR_REQ is ignored.
- Address arithmetic wraps modulo 2^`MEM_AW`; no carry is propagated into the bank.
- `img_sizen` changing mid-transfer has no effect until the next acceptance.
- `sd_lba` bits above 13 participate only in the `oob` compare, not in the address.

Test Plan:
- Drive 0 read, `img_size0` = 194816, lba = 3:
  - ack rises 1 cycle after `sd_rd[0]`.
  - 512 `mem_rd` at 23'h400600..23'h4007FF.
  - 512 `sd_buff_wr` pulses with addr 0..511 and data equal to memory contents.
  - ack then falls.
- Drive 1 write, lba = 0, initiator buffer loaded with a pattern, read latency 1:
  - 512 `mem_wr` at 23'h600000.. carrying the pattern bytes in order.
  - No `sd_buff_wr`.
- Out-of-range read, `img_size0` = 1024, lba = 2:
  - Zero `mem_rd`.
  - 512 strobes, all data 8'hFF.
  - The same case with a write gives zero `mem_wr`.
- Simultaneous `sd_rd` = 2'b10 and `sd_wr` = 2'b01:
  - Drive 0 write is served first.
  - Drive 1 read is accepted after DONE while `sd_rd[1]` is still held.
- `reset_n` pulsed low during byte 100 of a read with `mem_rd` pending:
  - `sd_ack`, `mem_rd` and `sd_buff_wr` go 0 immediately.
  - A fresh request after release restarts at byte 0.
- `mem_ready` delay randomised 1..20 cycles:
  - `mem_rd` held stable until ready.
  - No dropped or duplicated bytes; exactly 512 strobes.
